spi_responder: RTL and testbench
================================

SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per SPI word, MSB first.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on sclk, mosi and cs_n.
REQ-003 SHALL have port CLK, input, 1: single system clock (48 MHz); all state is in this domain.
REQ-004 SHALL have port RST_N, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port sclk, input, 1: SPI clock from the initiator, asynchronous to CLK.
REQ-006 SHALL have port cs_n, input, 1: chip select from the initiator, active-low, asynchronous.
REQ-007 SHALL have port mosi, input, 1: serial data from the initiator.
REQ-008 SHALL have port miso, output, 1: serial data to the initiator.
REQ-009 SHALL have port miso_oe, output, 1: pad enable for miso, high while a frame is active.
REQ-010 SHALL have port rx_data, output, DATA_W: last complete received word.
REQ-011 SHALL have port rx_valid, output, 1: one-CLK pulse when rx_data updates.
REQ-012 SHALL have port tx_data, input, DATA_W: next word to transmit.
REQ-013 SHALL have port tx_valid, input, 1: tx_data offered.
REQ-014 SHALL have port tx_ready, output, 1: one-entry tx holding buffer empty.
REQ-015 SHALL have port frame_active, output, 1: synchronized cs_n low.
REQ-016 SHALL have port tx_underrun, output, 1: one-CLK pulse when a word is loaded from an empty buffer.

Function
REQ-017 SHALL operate SPI mode 0 (CPOL=0, CPHA=0) and support sclk up to CLK/8.
REQ-018 SHALL pass sclk, cs_n and mosi through SYNC_STAGES flops, then edge-detect sclk and cs_n on the synchronized values.
REQ-019 SHALL implement states IDLE and ACTIVE: IDLE->ACTIVE on synchronized cs_n falling; ACTIVE->IDLE on synchronized cs_n rising.
REQ-020 SHALL, on IDLE->ACTIVE, clear the bit counter and load the tx shift register from the holding buffer, with miso showing the loaded MSB in the same cycle.
REQ-021 SHALL, in ACTIVE, on each synchronized sclk rising edge, shift mosi into the rx shift register LSB side and increment the bit counter.
REQ-022 SHALL, on the DATA_W-th rising edge, write the completed word to rx_data and pulse rx_valid in the next CLK cycle, then wrap the bit counter to 0.
REQ-023 SHALL, in ACTIVE, on each synchronized sclk falling edge with bit counter nonzero, shift the tx shift register left one bit (miso = new MSB).
REQ-024 SHALL, on the falling edge following a word wrap (counter 0), load the next word from the holding buffer instead of shifting.
REQ-025 SHALL accept a word on tx_valid && tx_ready in a cycle, filling the holding buffer; tx_ready SHALL then deassert until a load empties it.
REQ-026 SHALL, on a load with holding buffer empty, load all zeros and pulse tx_underrun; a handshake in the same cycle as that load SHALL NOT bypass and SHALL fill the buffer afterwards.
REQ-027 SHALL, on cs_n rising mid-word, discard partial rx and tx bits, produce no rx_valid, and keep unconsumed holding buffer content.
REQ-028 SHALL ignore sclk edges and mosi in IDLE.
REQ-029 SHALL drive miso_oe = frame_active and miso = 0 while miso_oe = 0.
REQ-030 SHALL hold rx_data stable between rx_valid pulses; rx_data SHALL NOT be back-pressured (a consumer missing a pulse loses no protocol state).

Reset
REQ-031 SHALL, while RST_N = 0, force: state IDLE, miso 0, miso_oe 0, rx_data 0, rx_valid 0, tx_ready 1, frame_active 0, tx_underrun 0, bit counter 0, shift registers 0, holding buffer empty.
REQ-032 SHALL preset the synchronizers to the idle bus (sclk 0, cs_n 1, mosi 0) so that reset release causes no spurious edge.
REQ-033 SHALL, on reset asserted mid-frame, abandon the frame; after release, resume only on a new cs_n falling edge.

Verification
REQ-034 SHALL pass: preload tx 0xA5, frame of one byte with mosi 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data 0x3C with one rx_valid pulse.
REQ-035 SHALL pass: two-byte frame, tx 0x81 then 0x7E supplied before the wrap falling edge, mosi 0x12,0x34 -> miso 0x81,0x7E; rx_valid twice with 0x12, 0x34.
REQ-036 SHALL pass: frame started with empty buffer -> miso 0x00, one tx_underrun pulse, tx_ready stays 1.
REQ-037 SHALL pass: cs_n raised after 5 bits -> no rx_valid; next full frame mosi 0xC3 -> rx_data 0xC3.
REQ-038 SHALL pass: RST_N low mid-frame -> all outputs at reset values immediately (asynchronous); after release, no rx_valid until a new frame completes.

Source files
------------

// File: rtl/spi_responder.sv
// SPI mode-0 responder: synchronizes the SPI pins into CLK, shifts rx/tx words
// MSB first and buffers one tx word ahead of the shifter.
module spi_responder #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              frame_active,
    output logic              tx_underrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   sclk_q;
    logic                   cs_q;
    logic                   armed;

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      rx_shift;
    logic [DATA_W-1:0]      tx_shift;
    logic [DATA_W-1:0]      hold;
    logic                   hold_full;
    logic                   word_done;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic do_load, accept;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    // A cs_n low level that was already present at reset release is not a
    // frame start: armed only sets once a genuine high level has been seen.
    assign cs_fall   = armed & cs_q & ~cs_s;
    assign cs_rise   = ~cs_q & cs_s;

    assign tx_ready  = ~hold_full;
    assign accept    = tx_valid & ~hold_full;
    assign do_load   = ((state == IDLE) && cs_fall) ||
                       ((state == ACTIVE) && !cs_rise && sclk_fall &&
                        (bit_cnt == '0) && word_done);

    assign frame_active = (state == ACTIVE);
    assign miso_oe      = (state == ACTIVE);
    assign miso         = (state == ACTIVE) & tx_shift[DATA_W-1];

    // Pin synchronizers, preset to the idle bus, plus edge-detect history.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            fill      <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= SYNC_STAGES'({sclk_sync, sclk});
            cs_sync   <= SYNC_STAGES'({cs_sync, cs_n});
            mosi_sync <= SYNC_STAGES'({mosi_sync, mosi});
            fill      <= SYNC_STAGES'({fill, 1'b1});
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
            armed     <= armed | (fill[SYNC_STAGES-1] & cs_s);
        end
    end

    // Frame FSM, shift registers and the one-entry tx holding buffer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            hold        <= '0;
            hold_full   <= 1'b0;
            word_done   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            if (do_load) begin
                if (hold_full) begin
                    tx_shift  <= hold;
                    hold_full <= 1'b0;
                end else begin
                    tx_shift    <= '0;
                    tx_underrun <= 1'b1;
                end
            end

            // Only possible while the buffer is empty, so it never collides
            // with a load draining the buffer in the same cycle.
            if (accept) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= ACTIVE;
                        bit_cnt   <= '0;
                        rx_shift  <= '0;
                        word_done <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        rx_shift  <= '0;
                        tx_shift  <= '0;
                        word_done <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift <= DATA_W'({rx_shift, mosi_s});
                        if (bit_cnt == CNT_W'(DATA_W-1)) begin
                            rx_data   <= DATA_W'({rx_shift, mosi_s});
                            rx_valid  <= 1'b1;
                            bit_cnt   <= '0;
                            word_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt != '0) begin
                            tx_shift <= tx_shift << 1;
                        end else if (word_done) begin
                            word_done <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: an SPI initiator drives frames while a reference
// model of the holding buffer predicts miso words, rx words and underruns.
`timescale 1ns/1ns
module tb_spi_responder;

    localparam int  W    = 8;
    localparam time HALF = 160;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         sclk = 1'b0;
    logic         cs_n = 1'b1;
    logic         mosi = 1'b0;
    logic         tx_valid = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         miso, miso_oe, rx_valid, tx_ready, frame_active, tx_underrun;
    logic [W-1:0] rx_data;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_rx[$];
    logic [W-1:0] exp_miso[$];
    logic [W-1:0] obs_miso[$];
    bit           m_full = 1'b0;
    logic [W-1:0] m_word = '0;
    int           exp_under = 0;
    int           seen_under = 0;
    logic [W-1:0] f_mosi[4];
    logic [W-1:0] f_tx[4];
    bit           f_sup[4];
    logic [W-1:0] mon_e, mon_o;

    always #10 CLK = ~CLK;

    spi_responder #(.DATA_W(W), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .frame_active(frame_active), .tx_underrun(tx_underrun)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_tx(input logic [W-1:0] w);
        @(negedge CLK);
        check("tx_ready_before_offer", {31'd0, tx_ready}, {31'd0, !m_full});
        tx_data  = w;
        tx_valid = 1'b1;
        @(posedge CLK);
        #1 tx_valid = 1'b0;
        m_word = w;
        m_full = 1'b1;
        @(negedge CLK);
        check("tx_ready_after_offer", {31'd0, tx_ready}, 32'd0);
    endtask

    // Reference load: the buffered word if any, else zeros and an underrun.
    task automatic model_load(output logic [W-1:0] w);
        if (m_full) begin
            w = m_word;
            m_full = 1'b0;
        end else begin
            w = '0;
            exp_under++;
        end
    endtask

    task automatic run_frame(input int n, input int abort_bits);
        logic [W-1:0] cap, ew;
        time t0;
        cap = '0;
        cs_n = 1'b0;
        model_load(ew);
        for (int k = 0; k < n; k++) begin
            if (abort_bits == 0) exp_rx.push_back(f_mosi[k]);
            for (int i = 0; i < W; i++) begin
                mosi = f_mosi[k][W-1-i];
                #(HALF);
                cap[W-1-i] = miso;
                sclk = 1'b1;
                t0 = $time;
                if (i == 1 && k + 1 < n && f_sup[k+1]) push_tx(f_tx[k+1]);
                #(HALF - ($time - t0));
                if (abort_bits > 0 && i == abort_bits - 1) begin
                    sclk = 1'b0;
                    #(HALF);
                    cs_n = 1'b1;
                    #(HALF * 2);
                    return;
                end
                if (i == W-1 && k == n-1) begin
                    cs_n = 1'b1;
                    #(HALF);
                    sclk = 1'b0;
                    #(HALF * 2);
                end else begin
                    sclk = 1'b0;
                end
            end
            exp_miso.push_back(ew);
            obs_miso.push_back(cap);
            if (k + 1 < n) model_load(ew);
        end
    endtask

    task automatic post_frame();
        check("underrun_count", seen_under, exp_under);
        check("tx_ready_idle", {31'd0, tx_ready}, {31'd0, !m_full});
        check("frame_inactive", {31'd0, frame_active}, 32'd0);
    endtask

    task automatic main_flow();
        logic [W-1:0] ew;
        #5;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_frame_active", {31'd0, frame_active}, 32'd0);
        check("rst_tx_underrun", {31'd0, tx_underrun}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (6) @(negedge CLK);

        // Preloaded single byte.
        push_tx(8'hA5);
        f_mosi[0] = 8'h3C;
        run_frame(1, 0);
        post_frame();

        // Two bytes, second tx word supplied during the first byte.
        push_tx(8'h81);
        f_mosi[0] = 8'h12; f_mosi[1] = 8'h34;
        f_sup[1] = 1'b1;   f_tx[1] = 8'h7E;
        run_frame(2, 0);
        post_frame();

        // Empty buffer at frame start.
        f_mosi[0] = W'($urandom);
        run_frame(1, 0);
        post_frame();

        // Abort after 5 bits, then a full frame.
        f_mosi[0] = W'($urandom);
        run_frame(1, 5);
        post_frame();
        f_mosi[0] = 8'hC3;
        run_frame(1, 0);
        post_frame();
        check("rx_data_held", {24'd0, rx_data}, 32'h0000_00C3);

        // Reset in the middle of a frame.
        push_tx(8'h5A);
        cs_n = 1'b0;
        model_load(ew);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'($urandom);
            #(HALF); sclk = 1'b1; #(HALF); sclk = 1'b0;
        end
        #(HALF / 2);
        RST_N = 1'b0;
        #1;
        check("midrst_miso", {31'd0, miso}, 32'd0);
        check("midrst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("midrst_frame_active", {31'd0, frame_active}, 32'd0);
        check("midrst_tx_underrun", {31'd0, tx_underrun}, 32'd0);
        m_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) RST_N = 1'b1;
            mosi = 1'($urandom);
            #(HALF); sclk = 1'b1; #(HALF); sclk = 1'b0;
        end
        check("no_resume_without_cs_edge", {31'd0, frame_active}, 32'd0);
        cs_n = 1'b1;
        #(HALF * 2);
        f_mosi[0] = W'($urandom);
        run_frame(1, 0);
        post_frame();

        // Randomized frames.
        for (int t = 0; t < 20; t++) begin
            int n, ab;
            n  = $urandom_range(1, 3);
            ab = 0;
            if ($urandom_range(0, 4) == 0) begin
                n  = 1;
                ab = $urandom_range(1, W-1);
            end
            for (int k = 0; k < 4; k++) begin
                f_mosi[k] = W'($urandom);
                f_tx[k]   = W'($urandom);
                f_sup[k]  = 1'($urandom);
            end
            if (!m_full && $urandom_range(0, 1) == 1) push_tx(W'($urandom));
            run_frame(n, ab);
            post_frame();
        end

        repeat (10) @(negedge CLK);
        check("rx_words_outstanding", exp_rx.size(), 32'd0);
        check("miso_words_outstanding", exp_miso.size(), 32'd0);
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge CLK);
                    if (rx_valid) begin
                        if (exp_rx.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rx_unexpected got=%0h expected=none at %0t", rx_data, $time);
                        end else begin
                            mon_e = exp_rx.pop_front();
                            check("rx_word", {24'd0, rx_data}, {24'd0, mon_e});
                        end
                    end
                    if (tx_underrun) seen_under++;
                    while (exp_miso.size() > 0 && obs_miso.size() > 0) begin
                        mon_e = exp_miso.pop_front();
                        mon_o = obs_miso.pop_front();
                        check("miso_word", {24'd0, mon_o}, {24'd0, mon_e});
                    end
                    check("miso_oe_vs_frame", {31'd0, miso_oe}, {31'd0, frame_active});
                    if (!miso_oe) check("miso_quiet", {31'd0, miso}, 32'd0);
                end
            end
            main_flow();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
